// File: rtl/mips_mem_arbiter.sv
// Two-master (ifetch/data) arbiter in front of mips_memory with one-cycle read response routing.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration instead of data-first fixed priority.
module mips_mem_arbiter #(
  parameter int RESP_HOLD = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_err,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_byte_en,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic        mem_wr_en,
  output logic        mem_read_en,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFETCH = 2'd1,
    OWN_DATA   = 2'd2
  } owner_e;

  logic   run_q, run_d;
  owner_e owner_q, owner_d;
  logic   i_elig, d_elig, i_win, d_win;

`ifdef MEM_ARB_RR_EN
  localparam logic LAST_IFETCH = 1'b0;
  localparam logic LAST_DATA   = 1'b1;
  logic last_q, last_d;
`endif

  // Arbitration: pick at most one eligible master this cycle
  always_comb begin
    i_elig = run_q & i_req & (i_addr[1:0] == 2'b00);
    d_elig = run_q & d_req;
`ifdef MEM_ARB_RR_EN
    if (i_elig && d_elig) begin
      d_win = (last_q == LAST_IFETCH);
      i_win = ~d_win;
    end else begin
      d_win = d_elig;
      i_win = i_elig;
    end
    if (i_win) begin
      last_d = LAST_IFETCH;
    end else if (d_win) begin
      last_d = LAST_DATA;
    end else begin
      last_d = last_q;
    end
`else
    d_win = d_elig;
    i_win = i_elig & ~d_elig;
`endif
  end

  assign i_gnt = i_win;
  assign d_gnt = d_win;
  assign i_err = run_q & i_req & (i_addr[1:0] != 2'b00);

  // Memory port mux and next read owner
  always_comb begin
    mem_address = 32'h0;
    mem_wr_en   = 1'b0;
    mem_read_en = 1'b0;
    mem_byte_en = 4'h0;
    mem_data_in = 32'h0;
    owner_d     = OWN_NONE;
    run_d       = 1'b1;
    if (i_win) begin
      mem_address = i_addr;
      mem_read_en = 1'b1;
      mem_byte_en = 4'hF;
      owner_d     = OWN_IFETCH;
    end else if (d_win) begin
      mem_address = d_addr;
      mem_byte_en = d_byte_en;
      if (d_we) begin
        mem_wr_en   = 1'b1;
        mem_data_in = d_wdata;
      end else begin
        mem_read_en = 1'b1;
        owner_d     = OWN_DATA;
      end
    end else begin
      owner_d = OWN_NONE;
    end
  end

  // Run flag, read owner and arbitration history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      owner_q <= OWN_NONE;
`ifdef MEM_ARB_RR_EN
      last_q  <= LAST_IFETCH;
`endif
    end else begin
      run_q   <= run_d;
      owner_q <= owner_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign i_rvalid = (owner_q == OWN_IFETCH);
  assign d_rvalid = (owner_q == OWN_DATA);

  generate
    if (RESP_HOLD != 0) begin : g_hold
      logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

      // Capture the response so it stays visible after the rvalid cycle
      always_comb begin
        i_rdata_d = i_rvalid ? mem_data_out : i_rdata_q;
        d_rdata_d = d_rvalid ? mem_data_out : d_rdata_q;
      end

      // Response hold registers
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          i_rdata_q <= 32'h0;
          d_rdata_q <= 32'h0;
        end else begin
          i_rdata_q <= i_rdata_d;
          d_rdata_q <= d_rdata_d;
        end
      end

      assign i_rdata = i_rdata_d;
      assign d_rdata = d_rdata_d;
    end else begin : g_pass
      assign i_rdata = mem_data_out;
      assign d_rdata = mem_data_out;
    end
  endgenerate

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed table, reset corner case, random traffic vs. a transaction model.
module tb_mips_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_byte_en;
  logic        i_gnt, i_err, i_rvalid, d_gnt, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_wr_en, mem_read_en;
  logic [3:0]  mem_byte_en;

  int vectors = 0;
  int miscompares = 0;

  mips_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_err(i_err),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byte_en(d_byte_en),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_read_en(mem_read_en),
    .mem_byte_en(mem_byte_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[31-8*k -: 8] = wd[31-8*k -: 8];
    end
    return r;
  endfunction

  // Memory stub: registered read, write committed at the edge; contents reset with the system
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 0) ? 32'h3C011234 : 32'h0;
      mem_data_out <= 32'h0;
    end else begin
      if (mem_wr_en) mem[mem_address[9:2]] <= merge(mem[mem_address[9:2]], mem_data_in, mem_byte_en);
      if (mem_read_en) mem_data_out <= mem[mem_address[9:2]];
    end
  end

  // Reference model state (transaction level)
  logic [31:0] shadow [256];
  logic        m_run;
  logic        m_last_data;
  logic        p_valid;
  logic        p_is_fetch;
  logic [31:0] p_data;
  logic [31:0] hold_i, hold_d;
  logic        e_ig, e_dg, e_ierr;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) shadow[i] = (i == 0) ? 32'h3C011234 : 32'h0;
    m_run = 1'b0; m_last_data = 1'b0; p_valid = 1'b0; p_is_fetch = 1'b0;
    p_data = 32'h0; hold_i = 32'h0; hold_d = 32'h0;
  endtask

  task automatic model_grants();
    logic want_i, want_d;
    want_i = m_run && reset_n && i_req && (i_addr[1:0] == 2'b00);
    want_d = m_run && reset_n && d_req;
    e_ierr = m_run && reset_n && i_req && (i_addr[1:0] != 2'b00);
    if (want_i && want_d) begin
`ifdef MEM_ARB_RR_EN
      e_dg = !m_last_data;
`else
      e_dg = 1'b1;
`endif
      e_ig = !e_dg;
    end else begin
      e_ig = want_i;
      e_dg = want_d;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic        ex_irv, ex_drv, ex_rd, ex_wr;
    logic [31:0] ex_ird, ex_drd, ex_addr, ex_din;
    logic [3:0]  ex_be;
    model_grants();
    ex_irv = p_valid && p_is_fetch;
    ex_drv = p_valid && !p_is_fetch;
    ex_ird = ex_irv ? p_data : hold_i;
    ex_drd = ex_drv ? p_data : hold_d;
    ex_addr = 32'h0; ex_din = 32'h0; ex_be = 4'h0; ex_rd = 1'b0; ex_wr = 1'b0;
    if (e_ig) begin
      ex_addr = i_addr; ex_rd = 1'b1; ex_be = 4'hF;
    end else if (e_dg) begin
      ex_addr = d_addr; ex_be = d_byte_en;
      ex_wr = d_we; ex_rd = !d_we; ex_din = d_we ? d_wdata : 32'h0;
    end
    chk("i_gnt", {31'h0, i_gnt}, {31'h0, e_ig});
    chk("d_gnt", {31'h0, d_gnt}, {31'h0, e_dg});
    chk("i_err", {31'h0, i_err}, {31'h0, e_ierr});
    chk("i_rvalid", {31'h0, i_rvalid}, {31'h0, ex_irv});
    chk("d_rvalid", {31'h0, d_rvalid}, {31'h0, ex_drv});
    chk("i_rdata", i_rdata, ex_ird);
    chk("d_rdata", d_rdata, ex_drd);
    chk("mem_address", mem_address, ex_addr);
    chk("mem_wr_en", {31'h0, mem_wr_en}, {31'h0, ex_wr});
    chk("mem_read_en", {31'h0, mem_read_en}, {31'h0, ex_rd});
    chk("mem_byte_en", {28'h0, mem_byte_en}, {28'h0, ex_be});
    chk("mem_data_in", mem_data_in, ex_din);
  endtask

  task automatic advance();
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      model_grants();
      if (p_valid && p_is_fetch) hold_i = p_data;
      if (p_valid && !p_is_fetch) hold_d = p_data;
      p_valid = e_ig || (e_dg && !d_we);
      p_is_fetch = e_ig;
      p_data = e_ig ? shadow[i_addr[9:2]] : shadow[d_addr[9:2]];
      if (e_dg && d_we) shadow[d_addr[9:2]] = merge(shadow[d_addr[9:2]], d_wdata, d_byte_en);
      if (e_ig) m_last_data = 1'b0;
      else if (e_dg) m_last_data = 1'b1;
      m_run = 1'b1;
    end
    #1;
  endtask

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        e_ig, e_dg, e_ierr, e_irv, e_drv;
    logic [31:0] e_ird, e_drd;
    logic        e_mrd, e_mwr;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 4'h1, 32'hAB000000,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3C011234, 32'h0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3C011234, 32'h0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3C011234, 32'hAB000000, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 32'hBFC00004, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3C011234, 32'hAB000000, 1'b1, 1'b0};
`ifdef MEM_ARB_RR_EN
    tbl[5] = '{1'b1, 32'hBFC00004, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3C011234, 32'hAB000000, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 32'hBFC00004, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'hAB000000, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 32'hBFC00004, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'hAB000000, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 32'hBFC00002, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
               1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'hAB000000, 1'b0, 1'b0};
`else
    for (int r = 5; r < 8; r++)
      tbl[r] = '{1'b1, 32'hBFC00004, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0,
                 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3C011234, 32'hAB000000, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 32'hBFC00002, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3C011234, 32'hAB000000, 1'b0, 1'b0};
`endif

    reset_n = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_byte_en = 4'h0; d_wdata = 32'h0;
    model_reset();

    // Held in reset: everything idle even with requests present
    for (int c = 0; c < 2; c++) begin
      i_req = (c == 1); i_addr = 32'hBFC00000; d_req = (c == 1);
      @(negedge clk); model_check();
      advance();
    end
    reset_n = 1'b1; d_req = 1'b0;
    @(negedge clk); model_check();
    chk("no_grant_before_first_edge", {31'h0, i_gnt}, 32'h0);
    advance();

    // Directed table
    for (int r = 0; r < 9; r++) begin
      i_req = tbl[r].i_req; i_addr = tbl[r].i_addr; d_req = tbl[r].d_req;
      d_we = tbl[r].d_we; d_addr = tbl[r].d_addr; d_byte_en = tbl[r].d_be;
      d_wdata = tbl[r].d_wdata;
      @(negedge clk);
      model_check();
      chk($sformatf("tbl%0d_i_gnt", r), {31'h0, i_gnt}, {31'h0, tbl[r].e_ig});
      chk($sformatf("tbl%0d_d_gnt", r), {31'h0, d_gnt}, {31'h0, tbl[r].e_dg});
      chk($sformatf("tbl%0d_i_err", r), {31'h0, i_err}, {31'h0, tbl[r].e_ierr});
      chk($sformatf("tbl%0d_i_rvalid", r), {31'h0, i_rvalid}, {31'h0, tbl[r].e_irv});
      chk($sformatf("tbl%0d_d_rvalid", r), {31'h0, d_rvalid}, {31'h0, tbl[r].e_drv});
      chk($sformatf("tbl%0d_i_rdata", r), i_rdata, tbl[r].e_ird);
      chk($sformatf("tbl%0d_d_rdata", r), d_rdata, tbl[r].e_drd);
      chk($sformatf("tbl%0d_mem_read_en", r), {31'h0, mem_read_en}, {31'h0, tbl[r].e_mrd});
      chk($sformatf("tbl%0d_mem_wr_en", r), {31'h0, mem_wr_en}, {31'h0, tbl[r].e_mwr});
      advance();
    end

    // Read granted, then reset asserted before the response edge
    i_req = 1'b1; i_addr = 32'hBFC00000; d_req = 1'b0;
    @(negedge clk); model_check();
    chk("midrst_grant", {31'h0, i_gnt}, 32'h1);
    #1 reset_n = 1'b0;
    model_reset();
    #1 model_check();
    chk("midrst_mem_read_en", {31'h0, mem_read_en}, 32'h0);
    advance();
    @(negedge clk); model_check();
    chk("midrst_i_rvalid", {31'h0, i_rvalid}, 32'h0);
    chk("midrst_d_rvalid", {31'h0, d_rvalid}, 32'h0);
    advance();
    reset_n = 1'b1;
    @(negedge clk); model_check();
    chk("release_no_grant", {31'h0, i_gnt}, 32'h0);
    advance();
    @(negedge clk); model_check();
    chk("release_then_grant", {31'h0, i_gnt}, 32'h1);
    advance();

    // Random traffic; masters hold requests until accepted or rejected
    i_req = 1'b0; d_req = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!i_req || e_ig || e_ierr) begin
        logic [7:0] idx;
        idx = 8'($urandom_range(0, 255));
        i_req = ($urandom_range(0, 9) < 6);
        i_addr = 32'hBFC00000 | {22'h0, idx, 2'b00};
        if ($urandom_range(0, 7) == 0) i_addr[1:0] = 2'($urandom_range(1, 3));
      end
      if (!d_req || e_dg) begin
        logic [7:0] idx;
        idx = 8'($urandom_range(0, 255));
        d_req = ($urandom_range(0, 9) < 6);
        d_we = 1'($urandom_range(0, 1));
        d_addr = {22'h0, idx, 2'b00};
        d_byte_en = 4'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      @(negedge clk);
      model_check();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
